// File: rtl/spi_slave_32bit.sv
// rtl/spi_slave_32bit.sv - SPI mode 0 peripheral, MSB first, one word per CS frame
module spi_slave_32bit #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SCLK,
  input  logic             CS,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic [WIDTH-1:0] data_out,
  output logic             rx_valid,
  output logic             busy,
  output logic             frame_err
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} state_t;

  state_t           state;
  logic             sclk_s, cs_s, mosi_s;
  logic             sclk_prev, cs_prev;
  logic             sclk_rise, sclk_fall, cs_fall;
  logic [WIDTH-1:0] tx_buf, shift_tx, shift_rx;
  logic [CNT_W-1:0] bit_cnt;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sclk_s = SCLK;
      assign cs_s   = CS;
      assign mosi_s = MOSI;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
      // Equal-depth synchronizers keep SCLK, CS and MOSI aligned to each other
      always_ff @(posedge clk) begin
        if (reset) begin
          sclk_q <= '0;
          cs_q   <= '1;
          mosi_q <= '0;
        end else begin
          sclk_q <= (sclk_q << 1) | SYNC_STAGES'(SCLK);
          cs_q   <= (cs_q << 1)   | SYNC_STAGES'(CS);
          mosi_q <= (mosi_q << 1) | SYNC_STAGES'(MOSI);
        end
      end
      assign sclk_s = sclk_q[SYNC_STAGES-1];
      assign cs_s   = cs_q[SYNC_STAGES-1];
      assign mosi_s = mosi_q[SYNC_STAGES-1];
    end
  endgenerate

  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_fall   = ~cs_s & cs_prev;

  // Frame FSM: edge history, tx buffering, shifting and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
      MISO      <= 1'b0;
      data_out  <= '0;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      tx_buf    <= '0;
      shift_tx  <= '0;
      shift_rx  <= '0;
      bit_cnt   <= '0;
    end else begin
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (tx_load) tx_buf <= tx_data;
      case (state)
        IDLE: begin
          MISO <= 1'b0;
          busy <= 1'b0;
          if (cs_fall) begin
            // A load coinciding with frame start wins over the older buffer
            shift_tx <= tx_load ? tx_data : tx_buf;
            MISO     <= tx_load ? tx_data[WIDTH-1] : tx_buf[WIDTH-1];
            bit_cnt  <= '0;
            shift_rx <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_s) begin
            // CS has priority over a simultaneous SCLK rise: abort the frame
            frame_err <= 1'b1;
            MISO      <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (sclk_rise) begin
            shift_rx <= {shift_rx[WIDTH-2:0], mosi_s};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(WIDTH - 1)) begin
              data_out <= {shift_rx[WIDTH-2:0], mosi_s};
              rx_valid <= 1'b1;
              MISO     <= 1'b0;
              state    <= WAIT_CS;
            end
          end else if (sclk_fall) begin
            shift_tx <= shift_tx << 1;
            MISO     <= shift_tx[WIDTH-2];
          end
        end
        WAIT_CS: begin
          MISO <= 1'b0;
          if (cs_s) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_32bit.sv
// tb/tb_spi_slave_32bit.sv - self-checking bench for spi_slave_32bit
module tb_spi_slave_32bit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        SCLK = 1'b0;
  logic        CS = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic [31:0] tx_data = '0;
  logic        tx_load = 1'b0;
  logic [31:0] data_out;
  logic        rx_valid;
  logic        busy;
  logic        frame_err;

  spi_slave_32bit #(.WIDTH(32), .SYNC_STAGES(0)) dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO),
    .tx_data(tx_data), .tx_load(tx_load), .data_out(data_out),
    .rx_valid(rx_valid), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mosi;
    logic [31:0] tx;
    int          load_mode;  // 0: load before frame, 1: load with CS fall, 2: no load
    int          nbits;
    int          extra;
    logic [31:0] exp_data;
    logic [31:0] exp_miso;
    int          exp_valid;
    int          exp_err;
  } vec_t;

  vec_t fixed_v[7];
  vec_t rnd_v[8];

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;

  always @(negedge clk) begin
    if (rx_valid) valid_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_frame(input logic [31:0] mosi_w, input int nbits, input int extra,
                           input int load_mode, input logic [31:0] tx_w,
                           output logic [31:0] miso_w);
    miso_w = '0;
    if (load_mode == 0) begin
      tx_data = tx_w; tx_load = 1'b1; tick(1); tx_load = 1'b0; tick(1);
    end
    if (load_mode == 1) begin
      tx_data = tx_w; tx_load = 1'b1;
    end
    CS = 1'b0;
    tick(1);
    tx_load = 1'b0;
    tick(1);
    for (int i = 0; i < nbits; i++) begin
      MOSI = mosi_w[31-i];
      miso_w = {miso_w[30:0], MISO};
      SCLK = 1'b1; tick(2);
      SCLK = 1'b0; tick(2);
    end
    for (int j = 0; j < extra; j++) begin
      MOSI = $urandom_range(0, 1);
      SCLK = 1'b1; tick(2);
      check("extra_miso_hi", {31'b0, MISO}, 32'h0);
      SCLK = 1'b0; tick(2);
      check("extra_miso_lo", {31'b0, MISO}, 32'h0);
    end
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int          v0, e0;
    logic [31:0] mw;
    v0 = valid_cnt;
    e0 = err_cnt;
    run_frame(v.mosi, v.nbits, v.extra, v.load_mode, v.tx, mw);
    if (v.nbits == 32) begin
      check({tag, "_busy_wait"}, {31'b0, busy}, 32'h1);
      check({tag, "_miso_wait"}, {31'b0, MISO}, 32'h0);
      check({tag, "_miso_word"}, mw, v.exp_miso);
      if (v.load_mode == 1) check({tag, "_first_bit"}, {31'b0, mw[31]}, {31'b0, v.exp_miso[31]});
    end
    CS = 1'b1;
    tick(1);
    check({tag, "_busy_end"}, {31'b0, busy}, 32'h0);
    tick(2);
    check({tag, "_rx_valid"}, valid_cnt - v0, v.exp_valid);
    check({tag, "_frame_err"}, err_cnt - e0, v.exp_err);
    check({tag, "_data_out"}, data_out, v.exp_data);
  endtask

  initial begin
    logic [31:0] tx_model;
    logic [31:0] rx_model;
    logic [31:0] mw;
    int          e0, v0;

    fixed_v[0] = '{32'hDEAD_BEEF, 32'hA5A5_1234, 0, 32, 0, 32'hDEAD_BEEF, 32'hA5A5_1234, 1, 0};
    fixed_v[1] = '{32'h0000_0001, 32'h0,         2, 32, 0, 32'h0000_0001, 32'hA5A5_1234, 1, 0};
    fixed_v[2] = '{32'h8000_0000, 32'h0,         2, 32, 0, 32'h8000_0000, 32'hA5A5_1234, 1, 0};
    fixed_v[3] = '{32'h1234_5678, 32'h0,         2, 10, 0, 32'h8000_0000, 32'h0,         0, 1};
    fixed_v[4] = '{32'hCAFE_F00D, 32'h2222_2222, 0, 32, 0, 32'hCAFE_F00D, 32'h2222_2222, 1, 0};
    fixed_v[5] = '{32'h1357_9BDF, 32'h1111_1111, 1, 32, 0, 32'h1357_9BDF, 32'h1111_1111, 1, 0};
    fixed_v[6] = '{32'hFFFF_FFFF, 32'h0,         2, 32, 3, 32'hFFFF_FFFF, 32'h1111_1111, 1, 0};

    // Reference model for the randomized frames: state after the reset sequence
    tx_model = 32'h0;
    rx_model = 32'h0F0F_0F0F;
    foreach (rnd_v[k]) begin
      rnd_v[k].mosi      = $urandom;
      rnd_v[k].tx        = $urandom;
      rnd_v[k].load_mode = $urandom_range(0, 2);
      rnd_v[k].nbits     = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 31) : 32;
      rnd_v[k].extra     = (rnd_v[k].nbits == 32) ? $urandom_range(0, 2) : 0;
      if (rnd_v[k].load_mode != 2) tx_model = rnd_v[k].tx;
      rnd_v[k].exp_miso  = tx_model;
      if (rnd_v[k].nbits == 32) begin
        rx_model = rnd_v[k].mosi;
        rnd_v[k].exp_valid = 1;
        rnd_v[k].exp_err   = 0;
      end else begin
        rnd_v[k].exp_valid = 0;
        rnd_v[k].exp_err   = 1;
      end
      rnd_v[k].exp_data = rx_model;
    end

    tick(2);
    check("rst_miso", {31'b0, MISO}, 32'h0);
    check("rst_data_out", data_out, 32'h0);
    check("rst_flags", {29'b0, rx_valid, busy, frame_err}, 32'h0);
    reset = 1'b0;
    tick(2);

    foreach (fixed_v[i]) apply_vec(fixed_v[i], $sformatf("fix%0d", i));

    // Reset in the middle of a frame, then a clean frame
    e0 = err_cnt;
    v0 = valid_cnt;
    run_frame(32'hAAAA_5555, 16, 0, 2, 32'h0, mw);
    reset = 1'b1;
    tick(1);
    check("midrst_miso", {31'b0, MISO}, 32'h0);
    check("midrst_data_out", data_out, 32'h0);
    check("midrst_flags", {29'b0, rx_valid, busy, frame_err}, 32'h0);
    reset = 1'b0;
    CS = 1'b1;
    tick(3);
    check("midrst_no_err", err_cnt - e0, 0);
    check("midrst_no_valid", valid_cnt - v0, 0);
    apply_vec('{32'h0F0F_0F0F, 32'h0, 2, 32, 0, 32'h0F0F_0F0F, 32'h0, 1, 0}, "postrst");

    foreach (rnd_v[i]) apply_vec(rnd_v[i], $sformatf("rnd%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
